// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/acknowledge port.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ack;
  modport master (output req, addr, input rdata, ack);
  modport slave  (input req, addr, output rdata, ack);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, instruction fetch over req/ack, and next-PC commit from branch/jump controls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       imem,
  input  logic               stall_i,
  input  logic               branch_eq_i,
  input  logic               branch_ne_i,
  input  logic               jump_i,
  input  logic               zero_i,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc_plus4_o,
  output logic [31:0]        instr_o,
  output logic [5:0]         op_o,
  output logic               exec_o
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
  state_t      state_q;
  logic [31:0] pc_q, instr_q, pc_d, pc_plus4, br_tgt, j_tgt;
  logic        taken;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign j_tgt    = {pc_plus4[31:28], instr_q[25:0], 2'b00};
  assign taken    = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);
  assign pc_d     = jump_i ? j_tgt : taken ? br_tgt : pc_plus4;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= FETCH;
        FETCH: if (imem.ack) begin
          instr_q <= imem.rdata;
          state_q <= EXEC;
        end
        EXEC: if (!stall_i) begin
          pc_q    <= pc_d;
          state_q <= FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign imem.req   = state_q == FETCH;
  assign imem.addr  = pc_q;
  assign exec_o     = state_q == EXEC;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4;
  assign instr_o    = instr_q;
  assign op_o       = instr_q[31:26];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: transaction-level randomized bench for fetch_unit with a next-PC reference model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0040;
  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic        beq = 1'b0, bne = 1'b0, jmp = 1'b0, zero = 1'b0;
  logic [31:0] pc, pc_plus4, instr;
  logic [5:0]  op;
  logic        exec;
  logic [31:0] exp_pc, exp_instr;
  int          checks = 0, failures = 0;
  fetch_unit_if imem();
  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .imem(imem), .stall_i(stall),
    .branch_eq_i(beq), .branch_ne_i(bne), .jump_i(jmp), .zero_i(zero),
    .pc_o(pc), .pc_plus4_o(pc_plus4), .instr_o(instr), .op_o(op), .exec_o(exec)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] iw,
                                             input logic e, input logic n, input logic j, input logic z);
    logic [31:0] p4;
    int off;
    p4  = p + 32'd4;
    off = int'($signed(iw[15:0]));
    if (j) return {p4[31:28], iw[25:0], 2'b00};
    if ((e && z) || (n && !z)) return p4 + 32'(off * 4);
    return p4;
  endfunction
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_req", imem.req, 0);
    check("rst_exec", exec, 0);
    check("rst_pc", pc, RST_PC);
    check("rst_instr", instr, 0);
    check("rst_op", op, 0);
    exp_pc = RST_PC;
    exp_instr = '0;
    imem.ack = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check("rst_hold_pc", pc, RST_PC);
    rst = 1'b0;
    #1;
    check("idle_req", imem.req, 0);
    check("idle_exec", exec, 0);
  endtask
  task automatic run_instr(input logic [31:0] iw, input int waits, input int stalls,
                           input logic e, input logic n, input logic j, input logic z,
                           input bit spur, input int abort);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      check("f_req", imem.req, 1);
      check("f_addr", imem.addr, exp_pc);
      check("f_pc", pc, exp_pc);
      check("f_exec", exec, 0);
      check("f_instr", instr, exp_instr);
      if (abort == 1 && i == waits) begin
        imem.ack = 1'b0;
        do_reset();
        return;
      end
      imem.ack = (i == waits);
      imem.rdata = (i == waits) ? iw : $urandom;
      {beq, bne, jmp, zero} = 4'($urandom);
      stall = 1'($urandom);
    end
    exp_instr = iw;
    for (int s = 0; s <= stalls; s++) begin
      @(negedge clk);
      check("x_exec", exec, 1);
      check("x_req", imem.req, 0);
      check("x_pc", pc, exp_pc);
      check("x_instr", instr, iw);
      check("x_op", op, iw[31:26]);
      check("x_pc4", pc_plus4, exp_pc + 32'd4);
      if (abort == 2) begin
        do_reset();
        return;
      end
      imem.ack = spur;
      imem.rdata = ~iw;
      stall = (s < stalls);
      {beq, bne, jmp, zero} = (s < stalls) ? 4'($urandom) : {e, n, j, z};
    end
    exp_pc = model_next(exp_pc, iw, e, n, j, z);
  endtask
  initial begin
    imem.ack = 1'b0;
    imem.rdata = '0;
    @(negedge clk);
    do_reset();
    run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr({6'h02, 26'h000_0040}, 0, 0, 0, 0, 1, 0, 0, 0);
    run_instr({6'h04, 10'h0, 16'hFFFE}, 0, 0, 1, 0, 0, 1, 0, 0);
    run_instr({6'h02, 26'h000_0040}, 0, 0, 0, 0, 1, 0, 0, 0);
    run_instr({6'h04, 10'h0, 16'hFFFE}, 0, 0, 1, 0, 0, 0, 0, 0);
    run_instr({6'h02, 26'h000_0040}, 0, 0, 0, 0, 1, 0, 0, 0);
    run_instr({6'h05, 10'h0, 16'hFFFE}, 0, 0, 0, 1, 0, 0, 0, 0);
    run_instr({6'h02, 26'h000_0000}, 0, 0, 0, 0, 1, 0, 0, 0);
    run_instr({6'h04, 10'h0, 16'hFFFE}, 0, 0, 1, 0, 0, 1, 0, 0);
    run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr({6'h02, 26'h3FF_FFFF}, 0, 0, 0, 0, 1, 0, 0, 0);
    run_instr({6'h02, 26'h000_0000}, 0, 0, 0, 0, 1, 0, 0, 0);
    run_instr({6'h02, 26'h000_0040}, 0, 0, 1, 0, 1, 1, 0, 0);
    run_instr(32'h8C22_0004, 3, 0, 0, 0, 0, 0, 0, 0);
    run_instr(32'hAC22_0008, 0, 2, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0043_0820, 0, 2, 0, 0, 0, 0, 1, 0);
    run_instr(32'h0043_0820, 2, 0, 0, 0, 0, 0, 0, 1);
    run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(32'h1234_5678, 1, 1, 0, 0, 0, 0, 0, 2);
    run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 60; k++)
      run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    @(negedge clk);
    check("end_addr", imem.addr, exp_pc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
